// File: rtl/ctrl_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, control bundle,
// FSM states and default widths.
package ctrl_pkg;

  localparam int DEF_INSTR_W    = 16;
  localparam int DEF_ALU_CTRL_W = 3;
  localparam int DEF_ACC_SEL_W  = 3;
  localparam int DEF_RPT_W      = 8;

  localparam logic [1:0] PC_HOLD = 2'b00;
  localparam logic [1:0] PC_NEXT = 2'b11;

  // Full-word opcodes
  localparam logic [15:0] opAPAC = 16'h7F8F;
  localparam logic [15:0] opPAC  = 16'h7F8E;
  localparam logic [15:0] opSPAC = 16'h7F90;
  localparam logic [15:0] opABS  = 16'h7F88;
  localparam logic [15:0] opZAC  = 16'h7F89;

  // Top-byte opcodes
  localparam logic [7:0] opADDH = 8'h60;
  localparam logic [7:0] opADDS = 8'h61;
  localparam logic [7:0] opAND  = 8'h79;
  localparam logic [7:0] opOR   = 8'h7A;
  localparam logic [7:0] opLACK = 8'h7E;
  localparam logic [7:0] opLDP  = 8'h6F;
  localparam logic [7:0] opLT   = 8'h6A;
  localparam logic [7:0] opLTA  = 8'h6C;
  localparam logic [7:0] opMPY  = 8'h6D;
  localparam logic [7:0] opRPTK = 8'h67;

  // Top-nibble opcodes
  localparam logic [3:0] opADD = 4'h0;
  localparam logic [3:0] opSUB = 4'h1;
  localparam logic [3:0] opLAC = 4'h2;

  typedef enum logic [1:0] {ISSUE, EXEC2, REPEAT} state_t;

  typedef struct packed {
    logic                      t_reg;
    logic                      p_reg;
    logic                      accum_reset;
    logic                      mult_in;
    logic                      ar_in;
    logic                      data_mux;
    logic                      data_ram_in;
    logic [1:0]                alu_in;
    logic [DEF_ACC_SEL_W-1:0]  accum_in;
    logic [1:0]                pc_in;
    logic [DEF_ALU_CTRL_W-1:0] alu;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP   = '0;
  localparam ctrl_t CTRL_RESET = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: 16-bit match beats top-byte match,
// which beats top-nibble match; anything unmatched is flagged illegal.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int INSTR_W = DEF_INSTR_W
) (
  input  logic [INSTR_W-1:0] instruction,
  output ctrl_t              ctrl,
  output logic               illegal,
  output logic               two_cycle,
  output logic               rptk
);

  logic [15:0] op16;
  logic [7:0]  op8;
  logic [3:0]  op4;
  logic        hit16;
  logic        hit8;

  assign op16 = instruction[INSTR_W-1 -: 16];
  assign op8  = instruction[INSTR_W-1 -: 8];
  assign op4  = instruction[INSTR_W-1 -: 4];

  // NOTE: every output of a combinational block gets a default up front so
  // no path through the case statements can leave one unassigned (latch).
  always_comb begin
    ctrl       = CTRL_NOP;
    ctrl.pc_in = PC_NEXT;
    illegal    = 1'b0;
    two_cycle  = 1'b0;
    rptk       = 1'b0;
    hit16      = 1'b1;
    hit8       = 1'b1;

    case (op16)
      opAPAC:  ctrl.alu_in = 2'd1;
      opPAC:   ctrl.accum_in = 3'd2;
      opSPAC:  begin ctrl.alu_in = 2'd1; ctrl.alu = 3'd1; end
      opABS:   ctrl.data_ram_in = 1'b1;
      opZAC:   ctrl.accum_reset = 1'b1;
      default: hit16 = 1'b0;
    endcase

    if (!hit16) begin
      case (op8)
        opADDH: begin ctrl.accum_in = 3'd3; ctrl.ar_in = 1'b1; end
        opADDS: begin ctrl.accum_in = 3'd1; ctrl.ar_in = 1'b1; end
        opAND: begin
          ctrl.alu_in = 2'd2; ctrl.ar_in = 1'b1; ctrl.data_ram_in = 1'b1; ctrl.alu = 3'd4;
        end
        opOR: begin
          ctrl.alu_in = 2'd2; ctrl.ar_in = 1'b1; ctrl.data_ram_in = 1'b1; ctrl.alu = 3'd5;
        end
        opLACK: begin ctrl.accum_in = 3'd3; ctrl.ar_in = 1'b1; ctrl.data_ram_in = 1'b1; end
        opLDP:  begin ctrl.t_reg = 1'b1; ctrl.ar_in = 1'b1; ctrl.data_ram_in = 1'b1; end
        opLT, opLTA: begin
          ctrl.t_reg = 1'b1; ctrl.alu_in = 2'd1; ctrl.ar_in = 1'b1; ctrl.data_ram_in = 1'b1;
          two_cycle = (op8 == opLTA);
        end
        opMPY: begin
          ctrl.t_reg = 1'b1; ctrl.ar_in = 1'b1; ctrl.data_ram_in = 1'b1; two_cycle = 1'b1;
        end
        opRPTK:  rptk = 1'b1;
        default: hit8 = 1'b0;
      endcase

      if (!hit8) begin
        case (op4)
          opADD:   begin ctrl.alu_in = 2'd3; ctrl.data_ram_in = 1'b1; end
          opSUB:   begin ctrl.alu_in = 2'd3; ctrl.data_ram_in = 1'b1; ctrl.alu = 3'd1; end
          opLAC:   ctrl.accum_in = 3'd3;
          default: illegal = 1'b1;
        endcase
      end
    end
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Registered control sequencer: accepts instruction words, drives the control
// bundle one cycle later and sequences two-cycle ops and RPTK repeats.
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int INSTR_W    = DEF_INSTR_W,
  parameter int ALU_CTRL_W = DEF_ALU_CTRL_W,
  parameter int ACC_SEL_W  = DEF_ACC_SEL_W,
  parameter int RPT_W      = DEF_RPT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instr_valid,
  input  logic [INSTR_W-1:0]    instruction,
  output logic                  instr_ready,
  input  logic                  exec_stall,
  output logic                  tReg_ctrl,
  output logic                  pReg_ctrl,
  output logic                  accumReset_ctrl,
  output logic                  multInMux_ctrl,
  output logic                  arInMux_ctrl,
  output logic                  dataMux_ctrl,
  output logic                  dataRamIn_ctrl,
  output logic [1:0]            aluInMux_ctrl,
  output logic [ACC_SEL_W-1:0]  accumInMux_ctrl,
  output logic [1:0]            pcInMux_ctrl,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic                  illegal_op,
  output logic                  busy
);

  state_t             state_q, state_d;
  logic [RPT_W-1:0]   rpt_cnt_q, rpt_cnt_d;
  logic               rpt_armed_q, rpt_armed_d;
  logic               rpt_active_q, rpt_active_d;
  logic [INSTR_W-1:0] rpt_word_q, rpt_word_d;
  ctrl_t              ctrl_q, ctrl_d;
  logic               illegal_q, illegal_d;

  logic [INSTR_W-1:0] dec_word;
  ctrl_t              dec_ctrl;
  logic               dec_illegal;
  logic               dec_two;
  logic               dec_rptk;
  logic               accept;

  assign instr_ready = (state_q == ISSUE) && !exec_stall && !reset;
  assign accept      = instr_valid && instr_ready;

  // While repeating, the decoder re-reads the latched word instead of the bus.
  assign dec_word = (state_q == REPEAT) ? rpt_word_q : instruction;

  ctrl_decode #(.INSTR_W(INSTR_W)) u_decode (
    .instruction (dec_word),
    .ctrl        (dec_ctrl),
    .illegal     (dec_illegal),
    .two_cycle   (dec_two),
    .rptk        (dec_rptk)
  );

  always_comb begin
    state_d      = state_q;
    rpt_cnt_d    = rpt_cnt_q;
    rpt_armed_d  = rpt_armed_q;
    rpt_active_d = rpt_active_q;
    rpt_word_d   = rpt_word_q;
    ctrl_d       = ctrl_q;
    illegal_d    = 1'b0;

    if (!exec_stall) begin
      case (state_q)
        ISSUE: begin
          ctrl_d = CTRL_NOP;
          if (accept) begin
            ctrl_d    = dec_ctrl;
            illegal_d = dec_illegal;
            if (dec_rptk) begin
              rpt_cnt_d   = instruction[RPT_W-1:0];
              rpt_armed_d = 1'b1;
            end else begin
              rpt_armed_d = 1'b0;
              // A zero count means a single plain issue, so REPEAT is skipped.
              if (rpt_armed_q && rpt_cnt_q != '0) begin
                ctrl_d.pc_in = PC_HOLD;
                rpt_word_d   = instruction;
                rpt_cnt_d    = rpt_cnt_q - RPT_W'(1);
                rpt_active_d = 1'b1;
              end
              if (dec_two)
                state_d = EXEC2;
              else if (rpt_armed_q && rpt_cnt_q != '0)
                state_d = REPEAT;
            end
          end
        end
        EXEC2: begin
          ctrl_d       = ctrl_q;
          ctrl_d.t_reg = 1'b0;
          ctrl_d.p_reg = 1'b1;
          ctrl_d.pc_in = PC_HOLD;
          state_d      = rpt_active_q ? REPEAT : ISSUE;
        end
        REPEAT: begin
          ctrl_d    = dec_ctrl;
          illegal_d = dec_illegal;
          if (rpt_cnt_q == '0) begin
            rpt_active_d = 1'b0;
            state_d      = dec_two ? EXEC2 : ISSUE;
          end else begin
            ctrl_d.pc_in = PC_HOLD;
            rpt_cnt_d    = rpt_cnt_q - RPT_W'(1);
            state_d      = dec_two ? EXEC2 : REPEAT;
          end
        end
        default: state_d = ISSUE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ISSUE;
      rpt_cnt_q    <= '0;
      rpt_armed_q  <= 1'b0;
      rpt_active_q <= 1'b0;
      rpt_word_q   <= '0;
      ctrl_q       <= CTRL_RESET;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rpt_cnt_q    <= rpt_cnt_d;
      rpt_armed_q  <= rpt_armed_d;
      rpt_active_q <= rpt_active_d;
      rpt_word_q   <= rpt_word_d;
      ctrl_q       <= ctrl_d;
      illegal_q    <= illegal_d;
    end
  end

  assign tReg_ctrl       = ctrl_q.t_reg;
  assign pReg_ctrl       = ctrl_q.p_reg;
  assign accumReset_ctrl = ctrl_q.accum_reset;
  assign multInMux_ctrl  = ctrl_q.mult_in;
  assign arInMux_ctrl    = ctrl_q.ar_in;
  assign dataMux_ctrl    = ctrl_q.data_mux;
  assign dataRamIn_ctrl  = ctrl_q.data_ram_in;
  assign aluInMux_ctrl   = ctrl_q.alu_in;
  assign accumInMux_ctrl = ctrl_q.accum_in;
  assign pcInMux_ctrl    = ctrl_q.pc_in;
  assign alu_ctrl        = ctrl_q.alu;
  assign illegal_op      = illegal_q;
  assign busy            = (state_q != ISSUE);

endmodule
